deserializer_ctrl: RTL



---
 rtl/deserializer_ctrl_if.sv | 29 ++
 rtl/deserializer_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/deserializer_ctrl_if.sv
// Handshake and status bundle between the serial-bit producer/word consumer
// and the deserializer controller.
interface deserializer_ctrl_if #(
   parameter int w  = 8,
   parameter int cw = 4
) ();
   logic          start;
   logic          bit_vld;
   logic          bit_in;
   logic          abort;
   logic          word_rdy;
   logic          clr_err;
   logic          word_vld;
   logic [w-1:0]  word;
   logic          busy;
   logic [cw-1:0] bit_cnt;
   logic          overrun;

   // The environment drives framing controls and consumes words and status
   modport master (
      output start, bit_vld, bit_in, abort, word_rdy, clr_err,
      input  word_vld, word, busy, bit_cnt, overrun
   );

   modport slave (
      input  start, bit_vld, bit_in, abort, word_rdy, clr_err,
      output word_vld, word, busy, bit_cnt, overrun
   );
endinterface

// File: rtl/deserializer_ctrl.sv
// Frames an LSB-first serial bit stream into w-bit words and hands them to a
// consumer over valid/ready, with one hold stage for a word awaiting drain.
module deserializer_ctrl #(
   parameter int w  = 8,
   parameter int cw = 4
) (
   input logic clk,
   input logic reset_n,
   deserializer_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

   state_t        state_q, state_d;
   logic [w-1:0]  sr_q, sr_d;
   logic [w-1:0]  word_q, word_d;
   logic [cw-1:0] cnt_q, cnt_d;
   logic          vld_q, vld_d;
   logic          ovr_q, ovr_d;
   logic          outFree;
   logic          lastBit;
   logic          dropBit;
   logic [w-1:0]  completed;

   // The output stage can take a new word if empty or being drained this cycle
   assign outFree   = !vld_q || bus.word_rdy;
   assign lastBit   = (cnt_q == cw'(w - 1));
   assign completed = {bus.bit_in, sr_q[w-1:1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      vld_d   = vld_q && !bus.word_rdy;
      dropBit = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d = SHIFT;
               sr_d    = '0;
               cnt_d   = '0;
            end
         end

         SHIFT: begin
            if (bus.abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (bus.bit_vld) begin
               if (lastBit && outFree) begin
                  word_d  = completed;
                  vld_d   = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (lastBit) begin
                  // Park the finished word in the shift register until drain
                  sr_d    = completed;
                  cnt_d   = cw'(w);
                  state_d = FULL;
               end else begin
                  sr_d  = completed;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         FULL: begin
            if (bus.abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               dropBit = bus.bit_vld;
               if (outFree) begin
                  word_d  = sr_q;
                  vld_d   = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      ovr_d = dropBit || (ovr_q && !bus.clr_err);
   end

   assign bus.word_vld = vld_q;
   assign bus.word     = word_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.bit_cnt  = cnt_q;
   assign bus.overrun  = ovr_q;

endmodule
